fsm_prog_engine: RTL

- Table-driven, programmable Moore FSM engine for the small control FSMs in this block family.
- Generalises the fixed 4-state / 2-bit-input controller: state count, input width and output width are parameters, and the transition and output tables are run-time writable.
- Adds input qualification, a dwell counter and a state-change strobe.
- Sits between an input-decode stage and downstream control logic; a config master loads the tables.

---
 rtl/fsm_prog_pkg.sv | 52 +++++
 rtl/fsm_prog_engine_if.sv | 34 +++
 rtl/fsm_prog_table.sv | 40 ++++
 rtl/fsm_prog_engine.sv | 114 +++++++++++
 4 files changed

// File: rtl/fsm_prog_pkg.sv
// Shared constants and default-table builders for the programmable FSM engine.
package fsm_prog_pkg;

  typedef enum logic {TblTrans, TblOut} tbl_kind_e;

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  // Base 4-state / 2-bit-input controller, flattened as row*4 + input
  localparam logic [1:0] DEF_TRANS [16] = '{
    S0, S1, S2, S3,
    S0, S3, S1, S3,
    S1, S3, S2, S0,
    S1, S0, S0, S3
  };
  localparam logic DEF_OUT [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  // clog2 with a floor of one bit
  function automatic int unsigned state_w(int unsigned n_states);
    return (n_states < 3) ? 1 : $clog2(n_states);
  endfunction

  function automatic int unsigned cfg_w(int unsigned sw, int unsigned ow);
    return (sw > ow) ? sw : ow;
  endfunction

  function automatic bit is_base(int unsigned n_states, int unsigned in_w);
    return (n_states == 4) && (in_w == 2);
  endfunction

  // Transition default at flat index idx = state * 2**in_w + input
  function automatic int unsigned default_trans(int unsigned n_states, int unsigned in_w,
                                                int unsigned idx);
    if (is_base(n_states, in_w)) return 32'(DEF_TRANS[idx[3:0]]);
    return idx >> in_w;  // self-loop: the row itself
  endfunction

  function automatic int unsigned default_out(int unsigned n_states, int unsigned in_w,
                                              int unsigned idx);
    if (is_base(n_states, in_w)) return 32'(DEF_OUT[idx[1:0]]);
    return 0;
  endfunction

  function automatic int unsigned table_default(tbl_kind_e kind, int unsigned n_states,
                                                int unsigned in_w, int unsigned idx);
    if (kind == TblTrans) return default_trans(n_states, in_w, idx);
    return default_out(n_states, in_w, idx);
  endfunction

endpackage

// File: rtl/fsm_prog_engine_if.sv
// Data and configuration bundle between the input decoder / config master and the engine.
interface fsm_prog_engine_if
  import fsm_prog_pkg::*;
#(
  parameter int unsigned STATE_W = 2,
  parameter int unsigned IN_W    = 2,
  parameter int unsigned OUT_W   = 1,
  parameter int unsigned DWELL_W = 8
);
  localparam int unsigned CFG_W = cfg_w(STATE_W, OUT_W);

  logic               in_valid;
  logic [IN_W-1:0]    input_signal;
  logic               cfg_we;
  logic               cfg_sel;
  logic [STATE_W-1:0] cfg_state;
  logic [IN_W-1:0]    cfg_input;
  logic [CFG_W-1:0]   cfg_data;
  logic               cfg_err;
  logic [STATE_W-1:0] current_state;
  logic [OUT_W-1:0]   output_signal;
  logic               state_changed;
  logic [DWELL_W-1:0] dwell_count;

  modport master (
    output in_valid, input_signal, cfg_we, cfg_sel, cfg_state, cfg_input, cfg_data,
    input  cfg_err, current_state, output_signal, state_changed, dwell_count
  );

  modport slave (
    input  in_valid, input_signal, cfg_we, cfg_sel, cfg_state, cfg_input, cfg_data,
    output cfg_err, current_state, output_signal, state_changed, dwell_count
  );
endinterface

// File: rtl/fsm_prog_table.sv
// Register-array lookup table: synchronous write, combinational read, reset to package defaults.
module fsm_prog_table
  import fsm_prog_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned AW       = 2,
  parameter tbl_kind_e   KIND     = TblTrans,
  parameter int unsigned N_STATES = 4,
  parameter int unsigned IN_W     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Reset reloads defaults and beats any write on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(table_default(KIND, N_STATES, IN_W, i));
      end
    end else if (we && (32'(waddr) < DEPTH)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Unpopulated addresses read as zero
  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) rdata = mem_q[raddr];
  end

endmodule

// File: rtl/fsm_prog_engine.sv
// Table-driven Moore FSM with input qualification, dwell counter and change strobe.
module fsm_prog_engine
  import fsm_prog_pkg::*;
#(
  parameter int unsigned N_STATES    = 4,
  parameter int unsigned IN_W        = 2,
  parameter int unsigned OUT_W       = 1,
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned DWELL_W     = 8
) (
  input logic               clk,
  input logic               reset,
  fsm_prog_engine_if.slave  bus
);

  localparam int unsigned STATE_W = state_w(N_STATES);
  localparam logic [STATE_W-1:0] RST_CODE = STATE_W'(RESET_STATE);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               changed_q, changed_d;
  logic               cfg_err_q, cfg_err_d;

  logic [STATE_W-1:0] trans_next;
  logic [OUT_W-1:0]   out_val;
  logic [STATE_W-1:0] cfg_next;
  logic [OUT_W-1:0]   cfg_out;
  logic               row_ok, data_ok, cfg_ok;
  logic               trans_we, out_we;

  // Range checks keep every stored next-state legal, so state_q never leaves 0..N_STATES-1
  always_comb begin
    cfg_next = bus.cfg_data[STATE_W-1:0];
    cfg_out  = bus.cfg_data[OUT_W-1:0];
    row_ok   = 32'(bus.cfg_state) < N_STATES;
    data_ok  = bus.cfg_sel || (32'(cfg_next) < N_STATES);
    cfg_ok   = row_ok && data_ok;
    trans_we = bus.cfg_we && cfg_ok && !bus.cfg_sel;
    out_we   = bus.cfg_we && cfg_ok && bus.cfg_sel;
  end

  fsm_prog_table #(
    .DEPTH    (N_STATES << IN_W),
    .WIDTH    (STATE_W),
    .AW       (STATE_W + IN_W),
    .KIND     (TblTrans),
    .N_STATES (N_STATES),
    .IN_W     (IN_W)
  ) u_trans (
    .clk   (clk),
    .reset (reset),
    .we    (trans_we),
    .waddr ({bus.cfg_state, bus.cfg_input}),
    .wdata (cfg_next),
    .raddr ({state_q, bus.input_signal}),
    .rdata (trans_next)
  );

  fsm_prog_table #(
    .DEPTH    (N_STATES),
    .WIDTH    (OUT_W),
    .AW       (STATE_W),
    .KIND     (TblOut),
    .N_STATES (N_STATES),
    .IN_W     (IN_W)
  ) u_out (
    .clk   (clk),
    .reset (reset),
    .we    (out_we),
    .waddr (bus.cfg_state),
    .wdata (cfg_out),
    .raddr (state_q),
    .rdata (out_val)
  );

  // State, dwell and strobe registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RST_CODE;
      dwell_q   <= '0;
      changed_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      changed_q <= changed_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next state reads the pre-write table entry, so a same-edge write is seen one cycle later
  always_comb begin
    state_d = state_q;
    if (bus.in_valid) state_d = trans_next;
    changed_d = (state_d != state_q);
    dwell_d   = dwell_q;
    if (changed_d) begin
      dwell_d = '0;
    end else if (dwell_q != '1) begin
      dwell_d = dwell_q + 1'b1;
    end
    cfg_err_d = bus.cfg_we && !cfg_ok;
  end

  // Moore outputs straight from registers
  always_comb begin
    bus.current_state = state_q;
    bus.output_signal = out_val;
    bus.state_changed = changed_q;
    bus.dwell_count   = dwell_q;
    bus.cfg_err       = cfg_err_q;
  end

endmodule
